// File: rtl/regfile_multiport_pkg.sv
// regfile_multiport_pkg: shared register-file sizing defaults and the hardwired-zero register index.
package regfile_multiport_pkg;
    localparam int RF_DW       = 32;
    localparam int RF_NREG     = 32;
    localparam int RF_AW       = 5;
    localparam int RF_NRD      = 2;
    localparam int RF_ZERO_REG = 0;
endpackage

// File: rtl/regfile_multiport_if.sv
// regfile_multiport_if: read, write and reserve ports of the GPR file; ID/WB side is master.
interface regfile_multiport_if import regfile_multiport_pkg::*; #(
    parameter int DW  = RF_DW,
    parameter int AW  = RF_AW,
    parameter int NRD = RF_NRD
);
    logic [NRD*AW-1:0] rdAddr;
    logic [NRD*DW-1:0] rdData;
    logic [NRD-1:0]    rdPending;
    logic              wrEn;
    logic [AW-1:0]     wrAddr;
    logic [DW-1:0]     wrData;
    logic              rsvEn;
    logic [AW-1:0]     rsvAddr;
    logic              anyPending;
    modport master (output rdAddr, wrEn, wrAddr, wrData, rsvEn, rsvAddr,
                    input rdData, rdPending, anyPending);
    modport slave  (input rdAddr, wrEn, wrAddr, wrData, rsvEn, rsvAddr,
                    output rdData, rdPending, anyPending);
endinterface

// File: rtl/regfile_multiport_scoreboard.sv
// regfile_scoreboard: per-register pending-write bits; a same-cycle reserve beats a clear, reg 0 never pends.
module regfile_scoreboard #(
    parameter int NREG = 32,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rsvEn,
    input  logic [AW-1:0]   rsvAddr,
    input  logic            clrEn,
    input  logic [AW-1:0]   clrAddr,
    output logic [NREG-1:0] pending,
    output logic            anyPending
);
    logic [NREG-1:0] setMask, clrMask;
    assign setMask = rsvEn ? NREG'(1) << rsvAddr : '0;
    assign clrMask = clrEn ? NREG'(1) << clrAddr : '0;
    always_ff @(posedge clk)
        pending <= rst ? '0 : ((pending & ~clrMask) | setMask) & ~NREG'(1);
    assign anyPending = |pending;
endmodule

// File: rtl/regfile_multiport.sv
// regfile_multiport: NRD-read/1-write GPR file with hardwired-zero r0 and RAW pending scoreboard.
// Define RF_BYPASS_EN to forward same-cycle WB data onto matching read ports.
module regfile_multiport import regfile_multiport_pkg::*; #(
    parameter int DW   = RF_DW,
    parameter int NREG = RF_NREG,
    parameter int AW   = RF_AW,
    parameter int NRD  = RF_NRD
) (
    input logic clk,
    input logic rst,
    regfile_multiport_if.slave bus
);
    logic [DW-1:0]   regs [NREG];
    logic [NREG-1:0] pending;

    always_ff @(posedge clk)
        if (rst)
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        else if (bus.wrEn && bus.wrAddr != AW'(RF_ZERO_REG))
            regs[bus.wrAddr] <= bus.wrData;

    regfile_scoreboard #(.NREG(NREG), .AW(AW)) sb (
        .clk        (clk),
        .rst        (rst),
        .rsvEn      (bus.rsvEn),
        .rsvAddr    (bus.rsvAddr),
        .clrEn      (bus.wrEn),
        .clrAddr    (bus.wrAddr),
        .pending    (pending),
        .anyPending (bus.anyPending)
    );

    for (genvar r = 0; r < NRD; r++) begin : g_rd
        logic [AW-1:0] a;
        logic fwd, keep;
        assign a = bus.rdAddr[r*AW +: AW];
`ifdef RF_BYPASS_EN
        assign fwd  = bus.wrEn && bus.wrAddr == a;
        assign keep = bus.rsvEn && bus.rsvAddr == a;
`else
        assign fwd  = 1'b0;
        assign keep = 1'b0;
`endif
        // a forwarded write retires the pending bit unless a younger producer reserves it now
        assign bus.rdData[r*DW +: DW] = a == AW'(RF_ZERO_REG) ? '0 : fwd ? bus.wrData : regs[a];
        assign bus.rdPending[r]       = pending[a] && (!fwd || keep);
    end
endmodule

// File: tb/tb_regfile_multiport.sv
// tb_regfile_multiport: scoreboard-driven bench for regfile_multiport; honours RF_BYPASS_EN.
module tb_regfile_multiport;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;
`ifdef RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    typedef struct {string name; int port; logic [31:0] data; logic pend;} exp_t;
    exp_t q[$];
    exp_t e;
    logic [31:0] mdl [32];
    logic [31:0] mp;

    regfile_multiport_if #(.DW(32), .AW(5), .NRD(2)) bus();
    regfile_multiport #(.DW(32), .NREG(32), .AW(5), .NRD(2)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input int wa, input logic [31:0] wd, input logic re, input int ra);
        bus.wrEn = we;
        bus.wrAddr = 5'(wa);
        bus.wrData = wd;
        bus.rsvEn = re;
        bus.rsvAddr = 5'(ra);
    endtask

    task automatic test_reset;
        drive(1, 1, 32'h11, 0, 0); step;
        drive(1, 2, 32'h22, 1, 3); step;
        drive(0, 0, 0, 0, 0);
        rst = 1'b1; step; rst = 1'b0;
        bus.rdAddr = {5'd2, 5'd1};
        q.push_back('{"rst r1", 0, 32'h0, 1'b0});
        q.push_back('{"rst r2", 1, 32'h0, 1'b0});
        #1;
        while (q.size() != 0) begin
            e = q.pop_front(); checks++;
            if (bus.rdData[e.port*32 +: 32] !== e.data || bus.rdPending[e.port] !== e.pend) begin
                failures++;
                $display("FAIL %s port%0d got data=%h pend=%b want data=%h pend=%b", e.name, e.port, bus.rdData[e.port*32 +: 32], bus.rdPending[e.port], e.data, e.pend);
            end
        end
        bus.rdAddr = {5'd0, 5'd3};
        q.push_back('{"rst r3", 0, 32'h0, 1'b0});
        #1;
        while (q.size() != 0) begin
            e = q.pop_front(); checks++;
            if (bus.rdData[e.port*32 +: 32] !== e.data || bus.rdPending[e.port] !== e.pend) begin
                failures++;
                $display("FAIL %s port%0d got data=%h pend=%b want data=%h pend=%b", e.name, e.port, bus.rdData[e.port*32 +: 32], bus.rdPending[e.port], e.data, e.pend);
            end
        end
        checks++;
        if (bus.anyPending !== 1'b0) begin
            failures++; $display("FAIL rst anyPending got %b want 0", bus.anyPending);
        end
    endtask

    task automatic test_write_read;
        drive(1, 5, 32'hDEADBEEF, 0, 0); step;
        drive(1, 0, 32'h1234, 0, 0); step;
        drive(0, 0, 0, 0, 0);
        bus.rdAddr = {5'd5, 5'd5};
        q.push_back('{"wr r5", 0, 32'hDEADBEEF, 1'b0});
        q.push_back('{"wr r5", 1, 32'hDEADBEEF, 1'b0});
        #1;
        while (q.size() != 0) begin
            e = q.pop_front(); checks++;
            if (bus.rdData[e.port*32 +: 32] !== e.data || bus.rdPending[e.port] !== e.pend) begin
                failures++;
                $display("FAIL %s port%0d got data=%h pend=%b want data=%h pend=%b", e.name, e.port, bus.rdData[e.port*32 +: 32], bus.rdPending[e.port], e.data, e.pend);
            end
        end
        bus.rdAddr = {5'd5, 5'd0};
        q.push_back('{"wr r0", 0, 32'h0, 1'b0});
        q.push_back('{"r5 p1", 1, 32'hDEADBEEF, 1'b0});
        #1;
        while (q.size() != 0) begin
            e = q.pop_front(); checks++;
            if (bus.rdData[e.port*32 +: 32] !== e.data || bus.rdPending[e.port] !== e.pend) begin
                failures++;
                $display("FAIL %s port%0d got data=%h pend=%b want data=%h pend=%b", e.name, e.port, bus.rdData[e.port*32 +: 32], bus.rdPending[e.port], e.data, e.pend);
            end
        end
    endtask

    task automatic test_scoreboard;
        drive(0, 0, 0, 1, 7); step;
        drive(0, 0, 0, 0, 0);
        bus.rdAddr = {5'd5, 5'd7};
        q.push_back('{"rsv r7", 0, 32'h0, 1'b1});
        q.push_back('{"rsv other", 1, 32'hDEADBEEF, 1'b0});
        #1;
        while (q.size() != 0) begin
            e = q.pop_front(); checks++;
            if (bus.rdData[e.port*32 +: 32] !== e.data || bus.rdPending[e.port] !== e.pend) begin
                failures++;
                $display("FAIL %s port%0d got data=%h pend=%b want data=%h pend=%b", e.name, e.port, bus.rdData[e.port*32 +: 32], bus.rdPending[e.port], e.data, e.pend);
            end
        end
        checks++;
        if (bus.anyPending !== 1'b1) begin
            failures++; $display("FAIL rsv anyPending got %b want 1", bus.anyPending);
        end
        drive(1, 7, 32'h55, 0, 0); step;
        drive(0, 0, 0, 0, 0);
        q.push_back('{"clr r7", 0, 32'h55, 1'b0});
        #1;
        while (q.size() != 0) begin
            e = q.pop_front(); checks++;
            if (bus.rdData[e.port*32 +: 32] !== e.data || bus.rdPending[e.port] !== e.pend) begin
                failures++;
                $display("FAIL %s port%0d got data=%h pend=%b want data=%h pend=%b", e.name, e.port, bus.rdData[e.port*32 +: 32], bus.rdPending[e.port], e.data, e.pend);
            end
        end
        checks++;
        if (bus.anyPending !== 1'b0) begin
            failures++; $display("FAIL clr anyPending got %b want 0", bus.anyPending);
        end
    endtask

    task automatic test_rsv_wr_same;
        drive(1, 9, 32'hA5, 1, 9); step;
        drive(0, 0, 0, 1, 0); step;
        drive(0, 0, 0, 0, 0);
        bus.rdAddr = {5'd0, 5'd9};
        q.push_back('{"rsv+wr r9", 0, 32'hA5, 1'b1});
        q.push_back('{"rsv r0", 1, 32'h0, 1'b0});
        #1;
        while (q.size() != 0) begin
            e = q.pop_front(); checks++;
            if (bus.rdData[e.port*32 +: 32] !== e.data || bus.rdPending[e.port] !== e.pend) begin
                failures++;
                $display("FAIL %s port%0d got data=%h pend=%b want data=%h pend=%b", e.name, e.port, bus.rdData[e.port*32 +: 32], bus.rdPending[e.port], e.data, e.pend);
            end
        end
        drive(1, 9, 32'hA6, 0, 0); step;
        drive(0, 0, 0, 0, 0);
        checks++;
        if (bus.anyPending !== 1'b0) begin
            failures++; $display("FAIL r9 retire anyPending got %b want 0", bus.anyPending);
        end
    endtask

    task automatic test_bypass;
        drive(1, 3, 32'h10, 0, 0); step;
        drive(1, 3, 32'h77, 0, 0);
        bus.rdAddr = {5'd3, 5'd3};
        q.push_back('{"wr-thru r3", 0, BYP ? 32'h77 : 32'h10, 1'b0});
        q.push_back('{"wr-thru r3", 1, BYP ? 32'h77 : 32'h10, 1'b0});
        #1;
        while (q.size() != 0) begin
            e = q.pop_front(); checks++;
            if (bus.rdData[e.port*32 +: 32] !== e.data || bus.rdPending[e.port] !== e.pend) begin
                failures++;
                $display("FAIL %s port%0d got data=%h pend=%b want data=%h pend=%b", e.name, e.port, bus.rdData[e.port*32 +: 32], bus.rdPending[e.port], e.data, e.pend);
            end
        end
        step;
        drive(0, 0, 0, 0, 0);
        q.push_back('{"after wr r3", 0, 32'h77, 1'b0});
        #1;
        while (q.size() != 0) begin
            e = q.pop_front(); checks++;
            if (bus.rdData[e.port*32 +: 32] !== e.data || bus.rdPending[e.port] !== e.pend) begin
                failures++;
                $display("FAIL %s port%0d got data=%h pend=%b want data=%h pend=%b", e.name, e.port, bus.rdData[e.port*32 +: 32], bus.rdPending[e.port], e.data, e.pend);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic we, re, hit;
        int wa, ra, a;
        logic [31:0] wd, d;
        drive(0, 0, 0, 0, 0);
        rst = 1'b1; step; rst = 1'b0;
        for (int k = 0; k < 32; k++) mdl[k] = '0;
        mp = '0;
        for (int n = 0; n < 120; n++) begin
            we = 1'($urandom_range(0, 1));
            re = $urandom_range(0, 2) == 0;
            wa = $urandom_range(0, 7);
            ra = $urandom_range(0, 7);
            wd = $urandom;
            drive(we, wa, wd, re, ra);
            bus.rdAddr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            for (int p = 0; p < 2; p++) begin
                a = int'(bus.rdAddr[p*5 +: 5]);
                hit = BYP && we && wa == a && a != 0;
                d = a == 0 ? 32'h0 : hit ? wd : mdl[a];
                q.push_back('{"b2b", p, d, mp[a] && !(hit && !(re && ra == a))});
            end
            #1;
            while (q.size() != 0) begin
                e = q.pop_front(); checks++;
                if (bus.rdData[e.port*32 +: 32] !== e.data || bus.rdPending[e.port] !== e.pend) begin
                    failures++;
                    $display("FAIL %s#%0d port%0d got data=%h pend=%b want data=%h pend=%b", e.name, n, e.port, bus.rdData[e.port*32 +: 32], bus.rdPending[e.port], e.data, e.pend);
                end
            end
            checks++;
            if (bus.anyPending !== (mp != 0)) begin
                failures++; $display("FAIL b2b#%0d anyPending got %b want %b", n, bus.anyPending, mp != 0);
            end
            if (we && wa != 0) mdl[wa] = wd;
            if (we) mp[wa] = 1'b0;
            if (re && ra != 0) mp[ra] = 1'b1;
            step;
        end
        drive(0, 0, 0, 0, 0);
    endtask

    task automatic test_reset_dominates;
        drive(1, 4, 32'h44, 0, 0); step;
        drive(1, 4, 32'h99, 1, 4);
        rst = 1'b1; step; rst = 1'b0;
        drive(0, 0, 0, 0, 0);
        bus.rdAddr = {5'd4, 5'd4};
        q.push_back('{"rst+wr r4", 0, 32'h0, 1'b0});
        q.push_back('{"rst+wr r4", 1, 32'h0, 1'b0});
        #1;
        while (q.size() != 0) begin
            e = q.pop_front(); checks++;
            if (bus.rdData[e.port*32 +: 32] !== e.data || bus.rdPending[e.port] !== e.pend) begin
                failures++;
                $display("FAIL %s port%0d got data=%h pend=%b want data=%h pend=%b", e.name, e.port, bus.rdData[e.port*32 +: 32], bus.rdPending[e.port], e.data, e.pend);
            end
        end
        checks++;
        if (bus.anyPending !== 1'b0) begin
            failures++; $display("FAIL rst+rsv anyPending got %b want 0", bus.anyPending);
        end
    endtask

    initial begin
        drive(0, 0, 0, 0, 0);
        bus.rdAddr = '0;
        step; step;
        rst = 1'b0;
        test_reset;
        test_write_read;
        test_scoreboard;
        test_rsv_wr_same;
        test_bypass;
        test_back_to_back;
        test_reset_dominates;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
